mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the core's fetch port and its load/store port.
- Sits between the pipelined core and unified memory. Serialises accesses and holds the core's pipeline stall while a request is pending.
- Data accesses have priority because they belong to the older instruction. A streak counter bounds fetch starvation.
- A watchdog completes any memory access that hangs.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the core's fetch and load/store ports.
// Data accesses win by default; a streak counter bounds fetch starvation and a watchdog ends hung accesses.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_rd,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  err
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic                  gnt_data_q,  gnt_data_d;
    logic [STREAK_W-1:0]   streak_q,    streak_d;
    logic [TMO_W-1:0]      tmo_q,       tmo_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_ack_q,    if_ack_d;
    logic                  d_ack_q,     d_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
    logic                  err_q,       err_d;

    logic d_req;
    logic data_wins;

    assign d_req     = d_rd | d_wr;
    assign data_wins = d_req & (~if_req | (streak_q < STREAK_MAX));

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (data_wins) begin
                    // Simultaneous d_rd/d_wr is illegal; the write takes precedence.
                    gnt_data_d  = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_req) begin
                    gnt_data_d = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    streak_d   = '0;
                end
                if (d_req || if_req) begin
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (gnt_data_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    // Hung access: complete it with zero data and flag it permanently.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    if (gnt_data_q) begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_data_q  <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_STREAK(MAX_STREAK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {mem_req, mem_we, if_ack, d_ack, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            errors++; $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        if_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_hold_req: got %b expected 0", mem_req);
        end
        if_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_fetch;
        do_reset;
        if_req = 1'b1; if_addr = 32'h0040_0000;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, stall, if_ack} !== 4'b1010 || mem_addr !== 32'h0040_0000) begin
            errors++; $display("FAIL fetch_busy1: got req/we/stall/ack=%b addr=%h expected 1010 00400000", {mem_req, mem_we, stall, if_ack}, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, stall, if_ack} !== 4'b1010) begin
            errors++; $display("FAIL fetch_busy2: got %b expected 1010", {mem_req, mem_we, stall, if_ack});
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if ({mem_req, if_ack, d_ack, stall} !== 4'b0100 || if_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL fetch_resp: got req/iack/dack/stall=%b rdata=%h expected 0100 00000013", {mem_req, if_ack, d_ack, stall}, if_rdata);
        end
        mem_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, if_ack} !== 2'b00 || if_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL fetch_after: got req/ack=%b rdata=%h expected 00 00000013", {mem_req, if_ack}, if_rdata);
        end
    endtask

    task automatic test_store;
        do_reset;
        d_wr = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h1001_0000 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_busy: got req/we=%b addr=%h wdata=%h expected 11 10010000 deadbeef", {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if ({mem_req, d_ack, if_ack, stall} !== 4'b0100) begin
            errors++; $display("FAIL store_resp: got req/dack/iack/stall=%b expected 0100", {mem_req, d_ack, if_ack, stall});
        end
        mem_ack = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_ack, if_ack, mem_req} !== 3'b000) begin
            errors++; $display("FAIL store_after: got dack/iack/req=%b expected 000", {d_ack, if_ack, mem_req});
        end
    endtask

    task automatic test_simultaneous;
        int g, iack_n, dack_n, dack_cyc, g2_cyc;
        logic [31:0] first_addr, second_addr;
        g = 0; iack_n = 0; dack_n = 0; dack_cyc = -100; g2_cyc = -1;
        first_addr = '0; second_addr = '0;
        do_reset;
        if_req = 1'b1; if_addr = 32'h0000_1000; d_rd = 1'b1; d_addr = 32'h0000_2000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (g == 0) first_addr = mem_addr;
                if (g == 1) begin second_addr = mem_addr; g2_cyc = c; end
                g++;
            end
            if (d_ack) begin
                dack_n++; dack_cyc = c; d_rd = 1'b0;
                checks++;
                if (d_rdata !== (32'h0000_2000 ^ 32'hA5A5_0000)) begin
                    errors++; $display("FAIL simul_drdata: got %h expected a5a52000", d_rdata);
                end
            end
            if (if_ack) begin
                iack_n++; if_req = 1'b0;
                checks++;
                if (if_rdata !== (32'h0000_1000 ^ 32'hA5A5_0000)) begin
                    errors++; $display("FAIL simul_irdata: got %h expected a5a51000", if_rdata);
                end
            end
            mem_ack = mem_req;
            mem_rdata = mem_addr ^ 32'hA5A5_0000;
        end
        mem_ack = 1'b0;
        checks++;
        if (g != 2 || first_addr !== 32'h0000_2000 || second_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL simul_order: got n=%0d first=%h second=%h expected 2 00002000 00001000", g, first_addr, second_addr);
        end
        checks++;
        if (iack_n != 1 || dack_n != 1) begin
            errors++; $display("FAIL simul_acks: got iack=%0d dack=%0d expected 1 1", iack_n, dack_n);
        end
        checks++;
        if (g2_cyc != dack_cyc + 2) begin
            errors++; $display("FAIL simul_fetch_timing: got cycle %0d expected %0d", g2_cyc, dack_cyc + 2);
        end
    endtask

    task automatic test_starvation;
        int n;
        logic [9:0] seq;
        n = 0; seq = '0;
        do_reset;
        if_req = 1'b1; if_addr = 32'h8000_0000; d_rd = 1'b1; d_addr = 32'h2000_0000;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin seq[n] = mem_addr[31]; n++; end
            mem_ack = mem_req;
            mem_rdata = $urandom;
            if (if_ack) if_addr = if_addr + 32'd4;
            if (d_ack) d_addr = d_addr + 32'd4;
        end
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL starve_timeout: got %0d grants expected 10", n);
        end
        // bit i set = fetch grant; four data grants precede each fetch
        checks++;
        if (seq !== 10'b10_0001_0000) begin
            errors++; $display("FAIL starve_order: got %b expected 1000010000", seq);
        end
    endtask

    task automatic test_random(input int n_cycles);
        logic exp_mreq, exp_we, exp_iack, exp_dack, exp_stall, gnt_data;
        logic [31:0] exp_addr, exp_wdata, exp_irdata, exp_drdata;
        logic arb_next, busy, gap, dp;
        int run, age, lat, fails_before;
        int unsigned op;
        exp_mreq = 0; exp_we = 0; exp_iack = 0; exp_dack = 0; gnt_data = 0;
        exp_addr = '0; exp_wdata = '0; exp_irdata = '0; exp_drdata = '0;
        arb_next = 1; busy = 0; gap = 0; run = 0; age = 0; lat = 0;
        fails_before = errors;
        do_reset;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== exp_mreq) begin
                errors++; $display("FAIL rnd_mem_req c=%0d: got %b expected %b", c, mem_req, exp_mreq);
            end
            if (exp_mreq) begin
                checks++;
                if (mem_we !== exp_we || mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wdata)) begin
                    errors++; $display("FAIL rnd_mem_cmd c=%0d: got we=%b addr=%h wd=%h expected %b %h %h", c, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
                end
            end
            checks++;
            if (if_ack !== exp_iack || d_ack !== exp_dack) begin
                errors++; $display("FAIL rnd_acks c=%0d: got i=%b d=%b expected %b %b", c, if_ack, d_ack, exp_iack, exp_dack);
            end
            checks++;
            if (if_rdata !== exp_irdata || d_rdata !== exp_drdata) begin
                errors++; $display("FAIL rnd_rdata c=%0d: got i=%h d=%h expected %h %h", c, if_rdata, d_rdata, exp_irdata, exp_drdata);
            end
            exp_stall = (if_req & ~exp_iack) | ((d_rd | d_wr) & ~exp_dack);
            checks++;
            if (stall !== exp_stall) begin
                errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, exp_stall);
            end
            if (errors - fails_before > 10) break;

            // Requesters: hold until ack, then maybe issue another request.
            if (exp_iack || !if_req) begin
                if_req = ($urandom_range(0, 2) != 0) && (exp_iack ? 1'b1 : ($urandom_range(0, 2) == 0));
                if (if_req) if_addr = $urandom;
            end
            if (exp_dack || !(d_rd | d_wr)) begin
                op = $urandom_range(0, 9);
                if (!exp_dack && $urandom_range(0, 1) == 0) op = 0;
                d_rd = (op >= 1 && op <= 4) || op == 9;
                d_wr = (op >= 5);
                d_addr = $urandom; d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            mem_ack = busy ? (age == lat) : ($urandom_range(0, 5) == 0);

            exp_iack = 0; exp_dack = 0;
            if (arb_next) begin
                dp = d_rd | d_wr;
                if (dp && (!if_req || run < MAX_STREAK)) begin
                    gnt_data = 1; exp_we = d_wr; exp_addr = d_addr; exp_wdata = d_wdata;
                    run = if_req ? run + 1 : 0;
                end else if (if_req) begin
                    gnt_data = 0; exp_we = 0; exp_addr = if_addr; run = 0;
                end
                if (dp || if_req) begin
                    exp_mreq = 1; busy = 1; age = 0; lat = $urandom_range(0, 4); arb_next = 0;
                end
            end else if (busy) begin
                if (mem_ack) begin
                    busy = 0; exp_mreq = 0; gap = 1;
                    if (gnt_data) begin exp_dack = 1; exp_drdata = mem_rdata; end
                    else begin exp_iack = 1; exp_irdata = mem_rdata; end
                end else begin
                    age++;
                end
            end else if (gap) begin
                gap = 0; arb_next = 1;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        logic done;
        int busy_n;
        do_reset;
        if_req = 1'b1; if_addr = 32'h0040_0100; mem_rdata = 32'h1234_5678;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
            if (if_ack) done = 1;
        end
        checks++;
        if (!done || if_rdata !== 32'h1234_5678 || err !== 1'b0) begin
            errors++; $display("FAIL tmo_prefetch: got done=%b rdata=%h err=%b expected 1 12345678 0", done, if_rdata, err);
        end
        if_addr = 32'h0040_0104; mem_ack = 1'b0;
        busy_n = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (mem_req) busy_n++;
            if (if_ack) begin
                done = 1;
                checks++;
                if (if_rdata !== 32'h0 || err !== 1'b1 || mem_req !== 1'b0) begin
                    errors++; $display("FAIL tmo_resp: got rdata=%h err=%b req=%b expected 0 1 0", if_rdata, err, mem_req);
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (!done || busy_n != TIMEOUT) begin
            errors++; $display("FAIL tmo_busy_len: got done=%b busy=%0d expected 1 %0d", done, busy_n, TIMEOUT);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 1'b1 || mem_req !== 1'b0 || if_ack !== 1'b0) begin
            errors++; $display("FAIL tmo_sticky: got err=%b req=%b ack=%b expected 1 0 0", err, mem_req, if_ack);
        end
    endtask

    task automatic test_reset_mid_busy;
        logic done;
        d_rd = 1'b1; d_addr = 32'h0000_3000; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL rmb_grant: got req=%b err=%b expected 1 1", mem_req, err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, d_ack, if_ack, err} !== 4'b0000) begin
            errors++; $display("FAIL rmb_after_rst: got req/dack/iack/err=%b expected 0000", {mem_req, d_ack, if_ack, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || d_ack !== 1'b0 || mem_addr !== 32'h0000_3000) begin
            errors++; $display("FAIL rmb_regrant: got req=%b dack=%b addr=%h expected 1 0 00003000", mem_req, d_ack, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (d_ack) begin
                done = 1;
                checks++;
                if (d_rdata !== 32'h0BAD_F00D || err !== 1'b0) begin
                    errors++; $display("FAIL rmb_rdata: got %h err=%b expected 0badf00d 0", d_rdata, err);
                end
                d_rd = 1'b0;
            end
            mem_ack = mem_req;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL rmb_timeout: got no d_ack expected one");
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        test_reset;
        test_single_fetch;
        test_store;
        test_simultaneous;
        test_starvation;
        test_random(4000);
        test_timeout;
        test_reset_mid_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got no finish expected finish before 2ms");
        $fatal(1, "simulation time limit");
    end

endmodule
